piso_tx_sched: RTL and testbench
================================

Name: piso_tx_sched

Overview:
- Round-robin scheduler that shares one piso_br_2 serializer among NREQ byte requesters.
- Accepts a byte from the winning requester via valid/ready and launches it with a one-cycle start pulse plus stable din.
- Holds off further launches for a fixed frame window so frames never overlap.
- Sits between the requester-side logic (command/status sources) and the single serial output lane.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, byte width; equals the serializer din width.
- FRAME_CYCLES, 54, clocks from the start-pulse edge until the serializer can take the next start (>=2).
- IDW, $clog2(NREQ), width of grant_id (localparam).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset; 0 resets all state immediately.
- en  input  1  1 = new grants allowed; 0 = no new grants, any in-flight frame completes.
- req_valid  input  NREQ  per-requester byte available; held until that requester's req_ready is seen.
- req_data  input  NREQ*DW  packed bytes; requester i drives bits [i*DW +: DW].
- req_ready  output  NREQ  one-hot, one-cycle pulse: byte i captured at the preceding edge.
- start  output  1  one-cycle launch pulse to the serializer.
- din  output  DW  byte to the serializer; valid with start, held until the next launch.
- busy  output  1  frame window active.
- grant_id  output  IDW  index of the last granted requester; held.
- frame_done  output  1  one-cycle pulse at the end of the frame window.

Behaviour:
- Reset (rst=0, asynchronous):
  - start=0, din=0, req_ready=0, busy=0, grant_id=0, frame_done=0.
  - State=IDLE, counter=0, RR pointer=0 (requester 0 has highest priority first).
- States: IDLE, LAUNCH, WAIT.
- IDLE: at an edge where en=1 and req_valid!=0:
  - Winner = first set bit scanning ptr, ptr+1, ... mod NREQ.
  - Registered at that edge (E0): din<=req_data[winner], start<=1, req_ready<=onehot(winner), grant_id<=winner, busy<=1, ptr<=(winner+1) mod NREQ.
  - Next state LAUNCH.
- LAUNCH: one cycle.
  - At edge E0+1: start<=0, req_ready<=0, counter<=FRAME_CYCLES-2; next state WAIT.
- WAIT: counter decrements each edge.
  - At the edge where counter==0 (E0+FRAME_CYCLES): busy<=0, frame_done<=1 for one cycle, state<=IDLE.
- Timing:
  - Earliest next grant is at edge E0+FRAME_CYCLES+1.
  - Minimum start-to-start spacing is FRAME_CYCLES+1 clocks (55 at defaults).
- Requester rule: keep valid and data stable until req_ready=1. The scheduler does not resample valid during LAUNCH/WAIT, so a requester may drop valid or change data on the edge after seeing ready.
- en=0 during LAUNCH/WAIT: no effect on the current frame; it only blocks the next grant. en=0 in IDLE: stay in IDLE, all outputs idle.
- Simultaneous valids: strict rotation. After winner k, requester k+1 has top priority; a requester that keeps valid asserted waits at most NREQ-1 frames.
- din is never changed outside a launch edge; it holds the last byte while idle.
- Reset mid-frame: start deasserts immediately, the frame is abandoned and no frame_done is issued. The serializer receives the same rst, so no partial-frame recovery is needed.
- Counter width is $clog2(FRAME_CYCLES); no arithmetic wrap is possible within range.

Decomposition:
- Shared package piso_pkg:
  - State encoding localparams S_IDLE=2'd0, S_LAUNCH=2'd1, S_WAIT=2'd2.
  - DW default and FRAME_CYCLES default.
- One natural sub-module, rr_arbiter: combinational, inputs req[NREQ] and ptr[IDW], outputs onehot grant and index. The top holds the FSM, counter, ptr and output registers.
- Integration: the top-level wrapper connects start/din directly to piso_br_2.

Test Plan:
- Reset: rst=0 at t=2 with req_valid=4'b1111 -> all outputs 0. After release, first grant goes to requester 0.
- Single request: req_valid=4'b0100, data[2]=8'hAA -> one start pulse with din=8'hAA, req_ready=4'b0100 for one cycle, grant_id=2, busy for 54 clocks, then one frame_done pulse.
- Fairness: req_valid=4'b1111 held, data i = 8'h10+i -> launch order 0,1,2,3,0 with din 10,11,12,13,10; start pulses exactly 55 clocks apart.
- Rotation skip: after a grant to 1, req_valid=4'b0001 -> next grant is 0 (wrap-around), ptr becomes 1.
- en gating: en=0 asserted mid-WAIT with valid pending -> current frame_done still occurs, no start until en=1, then launch on the next edge.
- Reset mid-frame: rst=0 at 20 clocks into WAIT -> start, busy and req_ready are 0 at once and no frame_done. After release, requester 0 has priority again.

Source files
------------

// File: rtl/piso_tx_sched_pkg.sv
// Shared state encoding and default sizing for the serializer scheduler.
package piso_pkg;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    localparam int DW_DEF           = 8;
    localparam int FRAME_CYCLES_DEF = 54;
endpackage

// File: rtl/piso_tx_sched_rr_arbiter.sv
// Rotating-priority pick: first set request scanning ptr, ptr+1, ... mod NREQ.
// Purely combinational; the caller owns ptr and decides when a grant is taken.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  index
);

    logic           hit;
    logic [IDW-1:0] k;

    always_comb begin
        grant = '0;
        index = '0;
        hit   = 1'b0;
        k     = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = IDW'((int'(ptr) + i) % NREQ);
            if (!hit && req[k]) begin
                hit      = 1'b1;
                grant[k] = 1'b1;
                index    = k;
            end
        end
    end

endmodule

// File: rtl/piso_tx_sched.sv
// Round-robin launcher sharing one serializer among NREQ byte sources.
// Grant to start: 1 edge; start-to-start >= FRAME_CYCLES+1; req_ready only while idle.
module piso_tx_sched
    import piso_pkg::*;
#(
    parameter  int NREQ         = 4,
    parameter  int DW           = DW_DEF,
    parameter  int FRAME_CYCLES = FRAME_CYCLES_DEF,
    localparam int IDW          = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               start,
    output logic [DW-1:0]      din,
    output logic               busy,
    output logic [IDW-1:0]     grant_id,
    output logic               frame_done
);

    localparam int CW = $clog2(FRAME_CYCLES);

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0] win_grant;
    logic [IDW-1:0]  win_idx;
    logic [DW-1:0]   win_byte;
    logic            grant_ok;

    logic [NREQ-1:0] req_ready_d;
    logic            start_d, busy_d, frame_done_d;
    logic [DW-1:0]   din_d;
    logic [IDW-1:0]  grant_id_d;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (win_grant),
        .index (win_idx)
    );

    assign win_byte = req_data[win_idx*DW +: DW];
    assign grant_ok = (state_q == S_IDLE) && en && (|req_valid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (grant_ok) state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT:   if (cnt_q == '0) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // start, req_ready and frame_done default low so they can only ever pulse.
    always_comb begin
        start_d      = 1'b0;
        req_ready_d  = '0;
        frame_done_d = 1'b0;
        busy_d       = busy;
        din_d        = din;
        grant_id_d   = grant_id;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (grant_ok) begin
                    start_d     = 1'b1;
                    req_ready_d = win_grant;
                    din_d       = win_byte;
                    grant_id_d  = win_idx;
                    busy_d      = 1'b1;
                    ptr_d       = IDW'((int'(win_idx) + 1) % NREQ);
                end
            end
            S_LAUNCH: cnt_d = CW'(FRAME_CYCLES - 2);
            S_WAIT: begin
                if (cnt_q == '0) begin
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start      <= 1'b0;
            req_ready  <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            din        <= '0;
            grant_id   <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
        end else begin
            start      <= start_d;
            req_ready  <= req_ready_d;
            frame_done <= frame_done_d;
            busy       <= busy_d;
            din        <= din_d;
            grant_id   <= grant_id_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_piso_tx_sched.sv
// Directed bench for piso_tx_sched with a per-cycle frame-timing model.
module tb_piso_tx_sched;
    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int FC   = 54;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en  = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [DW-1:0]     dat [NREQ];
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              start, busy, frame_done;
    logic [DW-1:0]     din;
    logic [1:0]        grant_id;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    assign req_data = {dat[3], dat[2], dat[1], dat[0]};

    piso_tx_sched #(.NREQ(NREQ), .DW(DW), .FRAME_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .start(start), .din(din), .busy(busy),
        .grant_id(grant_id), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: a frame launched at cycle L owns the lane for cycles L..L+FC,
    // and a new launch may happen no earlier than cycle L+FC+1.
    bit         m_act = 1'b0;
    int         m_last = 0;
    int         m_ptr = 0;
    int         m_gid = 0;
    logic [7:0] m_din = '0;

    task automatic model_step();
        bit allowed;
        bit found;
        int k;
        if (!rst) begin
            m_act = 1'b0; m_ptr = 0; m_gid = 0; m_din = '0;
        end else begin
            allowed = !m_act || (cyc >= m_last + FC + 1);
            found = 1'b0;
            if (allowed && en && (|req_valid)) begin
                for (int i = 0; i < NREQ; i++) begin
                    k = (m_ptr + i) % NREQ;
                    if (!found && req_valid[k]) begin
                        found = 1'b1;
                        m_gid = k;
                        m_din = dat[k];
                        m_ptr = (k + 1) % NREQ;
                        m_last = cyc;
                        m_act = 1'b1;
                    end
                end
            end else if (allowed) begin
                m_act = 1'b0;
            end
        end
    endtask

    task automatic model_cmp();
        int d;
        logic e_start, e_busy, e_fd;
        logic [3:0] e_rdy;
        d = cyc - m_last;
        e_start = m_act && (d == 0);
        e_busy  = m_act && (d < FC);
        e_fd    = m_act && (d == FC);
        e_rdy   = e_start ? 4'(1 << m_gid) : 4'b0;
        chk("cycle{start,busy,fd,rdy,gid,din}",
            32'({start, busy, frame_done, req_ready, grant_id, din}),
            32'({e_start, e_busy, e_fd, e_rdy, 2'(m_gid), m_din}));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
            #1;
            model_cmp();
        end
    end

    task automatic wait_start(output int at);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #2;
            if (start) begin
                at = cyc;
                break;
            end
        end
        tests++;
        if (at < 0) begin
            fails++;
            $display("FAIL start_timeout: got no start expected one within 200 cycles");
        end
    endtask

    task automatic do_req(input logic [3:0] v, input int eg, input logic [7:0] ed, input string nm);
        int at;
        @(negedge clk);
        req_valid = v;
        wait_start(at);
        chk({nm, "_gid"}, 32'(grant_id), 32'(eg));
        chk({nm, "_din"}, 32'(din), 32'(ed));
        chk({nm, "_rdy"}, 32'(req_ready), 32'(1 << eg));
        @(negedge clk);
        req_valid = '0;
    endtask

    initial begin
        int at [5];
        int nb;
        int ns;
        bit seen;
        for (int i = 0; i < NREQ; i++) dat[i] = 8'(8'h10 + i);

        // Reset with all requesters asking.
        req_valid = 4'b1111;
        #2 rst = 1'b0;
        #1;
        chk("rst_start", 32'(start), 0);
        chk("rst_din", 32'(din), 0);
        chk("rst_rdy", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gid", 32'(grant_id), 0);
        chk("rst_fd", 32'(frame_done), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Fairness: 0,1,2,3,0 spaced FC+1 apart.
        for (int i = 0; i < 5; i++) begin
            wait_start(at[i]);
            chk("fair_gid", 32'(grant_id), 32'(i % 4));
            chk("fair_din", 32'(din), 32'(8'h10 + (i % 4)));
        end
        for (int i = 1; i < 5; i++) chk("fair_spacing", 32'(at[i] - at[i-1]), 55);
        @(negedge clk);
        req_valid = '0;

        // Single request from requester 2.
        dat[2] = 8'hAA;
        @(negedge clk);
        req_valid = 4'b0100;
        wait_start(at[0]);
        chk("single_din", 32'(din), 32'h0AA);
        chk("single_gid", 32'(grant_id), 2);
        chk("single_rdy", 32'(req_ready), 32'b0100);
        @(negedge clk);
        req_valid = '0;
        nb = 1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #2;
            if (busy) nb++;
            else break;
        end
        chk("single_busy_len", 32'(nb), 54);
        chk("single_fd", 32'(frame_done), 1);

        // Rotation with wrap-around; ptr ends at 1.
        do_req(4'b0010, 1, 8'h11, "rot1");
        do_req(4'b0001, 0, 8'h10, "wrap");
        do_req(4'b1111, 1, 8'h11, "ptr1");

        // en dropped mid-WAIT with a request pending.
        do_req(4'b0100, 2, 8'hAA, "en_pre");
        repeat (10) @(negedge clk);
        en = 1'b0;
        req_valid = 4'b1000;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2;
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("en_fd_seen", 32'(seen), 1);
        ns = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            if (start) ns++;
        end
        chk("en_blocked", 32'(ns), 0);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #2;
        chk("en_launch", 32'(start), 1);
        chk("en_gid", 32'(grant_id), 3);
        chk("en_din", 32'(din), 32'h13);
        @(negedge clk);
        req_valid = '0;

        // Reset 20 clocks into WAIT.
        do_req(4'b0001, 0, 8'h10, "mid");
        repeat (19) @(negedge clk);
        req_valid = 4'b1111;
        rst = 1'b0;
        #1;
        chk("midrst_start", 32'(start), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_rdy", 32'(req_ready), 0);
        chk("midrst_fd", 32'(frame_done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_start(at[0]);
        chk("post_rst_gid", 32'(grant_id), 0);
        chk("post_rst_din", 32'(din), 32'h10);
        @(negedge clk);
        req_valid = '0;
        repeat (60) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
